// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the Core's TX byte strobe and a UART
// transmitter. Bytes from the Core are absorbed into a circular buffer.
// A small launch FSM drains the buffer one byte at a time. For each byte it
// pulses Tx_DV_out, then waits for Tx_Done_in, then spends one guard cycle
// before it launches the next byte.
//
// Optional feature: define UART_TX_FIFO_WATCHDOG_EN to add a BUSY-state
// watchdog and the sticky Timeout_out port. When the watchdog is enabled and
// the transmitter has not answered after TIMEOUT_CYC cycles in BUSY, the
// popped byte is abandoned and the FSM moves on.
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              In_DV_in,
    input  logic [7:0]        In_Byte_in,
    input  logic              Tx_Done_in,
    output logic              Tx_DV_out,
    output logic [7:0]        Tx_Byte_out,
    output logic              Full_out,
    output logic              Empty_out,
    output logic [ADDR_W:0]   Count_out,
    output logic              Overflow_out
`ifdef UART_TX_FIFO_WATCHDOG_EN
    ,
    output logic              Timeout_out
`endif
);

    // Reject configurations the pointer arithmetic cannot support.
    // Pointer wrap depends on DEPTH being exactly 2**ADDR_W.
    if (DEPTH < 2 || DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two >= 2 equal to 2**ADDR_W");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("uart_tx_fifo: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    state_t            state;
    state_t            state_next;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic              pop;
    logic              push;
    logic              drop;

`ifdef UART_TX_FIFO_WATCHDOG_EN
    localparam int           WD_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;
    logic            timeout_hit;

    // The counter reads TIMEOUT_CYC-1 during the TIMEOUT_CYC-th BUSY cycle.
    assign wd_expire = (wd_cnt == WD_LAST);
`endif

    // A full FIFO can still accept a byte when the head leaves at the same edge.
    assign push = In_DV_in && (!Full_out || pop);
    assign drop = In_DV_in && !push;

    assign Count_out = count;

    // Launch FSM next-state; the pop happens only on the IDLE->LAUNCH edge.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
`ifdef UART_TX_FIFO_WATCHDOG_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = LAUNCH;
                    pop        = 1'b1;
                end
            end
            LAUNCH: begin
                state_next = BUSY;
            end
            BUSY: begin
                if (Tx_Done_in) begin
                    state_next = GAP;
                end
`ifdef UART_TX_FIFO_WATCHDOG_EN
                else if (wd_expire) begin
                    state_next  = GAP;
                    timeout_hit = 1'b1;
                end
`endif
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Occupancy after this edge's push/pop; a simultaneous push and pop cancel out.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pointers, occupancy and status flags, all registered from count_next.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            Full_out     <= 1'b0;
            Empty_out    <= 1'b1;
            Overflow_out <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count     <= count_next;
            Full_out  <= (count_next == FULL_CNT);
            Empty_out <= (count_next == '0);
            if (drop) begin
                Overflow_out <= 1'b1;
            end
        end
    end

    // Storage array; holds data only, so it is never cleared.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= In_Byte_in;
        end
    end

    // Transmitter interface: the strobe follows pop, and the byte is held until the next pop.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            Tx_DV_out   <= 1'b0;
            Tx_Byte_out <= 8'h00;
        end else begin
            Tx_DV_out <= pop;
            if (pop) begin
                Tx_Byte_out <= mem[rd_ptr];
            end
        end
    end

`ifdef UART_TX_FIFO_WATCHDOG_EN
    // Watchdog: cleared on the way into BUSY, counts every BUSY cycle, and sets a sticky flag on expiry.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wd_cnt      <= '0;
            Timeout_out <= 1'b0;
        end else begin
            if (state == LAUNCH) begin
                wd_cnt <= '0;
            end else if (state == BUSY) begin
                wd_cnt <= wd_cnt + WD_ONE;
            end
            if (timeout_hit) begin
                Timeout_out <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo. A byte scoreboard is filled as bytes are
// pushed and is emptied by a strobe monitor. A transmitter model can answer
// each strobe with a Tx_Done_in pulse 20 cycles later.
module tb_uart_tx_fifo;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       In_DV_in = 1'b0;
    logic [7:0] In_Byte_in = 8'h00;
    logic       Tx_Done_in;
    logic       Tx_DV_out;
    logic [7:0] Tx_Byte_out;
    logic       Full_out;
    logic       Empty_out;
    logic [4:0] Count_out;
    logic       Overflow_out;
`ifdef UART_TX_FIFO_WATCHDOG_EN
    logic       Timeout_out;
`endif

    logic       man_done = 1'b0;
    logic       tx_done_model = 1'b0;
    bit         model_en = 1'b0;
    int         countdown = 0;

    int         vectors = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_edge = 0;
    bit         have_done = 1'b0;
    int         strobe_cnt = 0;
    logic       prev_dv = 1'b0;
    logic [7:0] exp_q[$];
    int         snap;

    assign Tx_Done_in = man_done | tx_done_model;

`ifdef UART_TX_FIFO_WATCHDOG_EN
    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4), .TIMEOUT_CYC(8)) dut (
`else
    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
`endif
        .CLK(CLK),
        .RST(RST),
        .In_DV_in(In_DV_in),
        .In_Byte_in(In_Byte_in),
        .Tx_Done_in(Tx_Done_in),
        .Tx_DV_out(Tx_DV_out),
        .Tx_Byte_out(Tx_Byte_out),
        .Full_out(Full_out),
        .Empty_out(Empty_out),
        .Count_out(Count_out),
        .Overflow_out(Overflow_out)
`ifdef UART_TX_FIFO_WATCHDOG_EN
        ,
        .Timeout_out(Timeout_out)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edge counter and record of the edge that sampled each done pulse.
    always @(posedge CLK) begin
        cyc++;
        if (Tx_Done_in === 1'b1) begin
            done_edge = cyc;
            have_done = 1'b1;
        end
    end

    // Strobe monitor: checks the one-cycle pulse, the byte order and the done-to-strobe spacing.
    always @(negedge CLK) begin
        if (Tx_DV_out === 1'b1) begin
            chk("dv_one_cycle", prev_dv, 1'b0);
            strobe_cnt++;
            chk("sb_nonempty", (exp_q.size() > 0), 1'b1);
            if (exp_q.size() > 0) chk("tx_byte", Tx_Byte_out, exp_q.pop_front());
            if (have_done) begin
                chk("done_to_dv", cyc, done_edge + 2);
                have_done = 1'b0;
            end
        end
        prev_dv = Tx_DV_out;
    end

    // Transmitter model: answers each strobe with a done pulse 20 cycles later.
    always @(negedge CLK) begin
        tx_done_model = 1'b0;
        if (Tx_DV_out === 1'b1 && model_en) begin
            countdown = 20;
        end else if (countdown > 0) begin
            countdown--;
            if (countdown == 0) tx_done_model = 1'b1;
        end
    end

    task automatic push(input logic [7:0] b, input bit accept);
        In_DV_in = 1'b1;
        In_Byte_in = b;
        if (accept) exp_q.push_back(b);
        @(negedge CLK);
        In_DV_in = 1'b0;
    endtask

    task automatic send_done();
        man_done = 1'b1;
        @(negedge CLK);
        man_done = 1'b0;
    endtask

    task automatic wait_strobe(input int limit);
        int n;
        n = 0;
        while (Tx_DV_out !== 1'b1 && n < limit) begin
            @(negedge CLK);
            n++;
        end
        chk("strobe_seen", Tx_DV_out, 1'b1);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_sb", exp_q.size(), 0);
        repeat (30) @(negedge CLK);
        chk("drain_empty", Empty_out, 1'b1);
        chk("drain_count", Count_out, 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_count"}, Count_out, 0);
        chk({tag, "_empty"}, Empty_out, 1'b1);
        chk({tag, "_full"}, Full_out, 1'b0);
        chk({tag, "_dv"}, Tx_DV_out, 1'b0);
        chk({tag, "_byte"}, Tx_Byte_out, 8'h00);
        chk({tag, "_ovf"}, Overflow_out, 1'b0);
`ifdef UART_TX_FIFO_WATCHDOG_EN
        chk({tag, "_tmo"}, Timeout_out, 1'b0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset("rst0");
        RST = 1'b1;
        @(negedge CLK);

`ifndef UART_TX_FIFO_WATCHDOG_EN
        // Single byte: strobe one edge after the push, then nothing more until done.
        push(8'hA5, 1'b1);
        chk("a5_count1", Count_out, 1);
        chk("a5_empty0", Empty_out, 1'b0);
        chk("a5_dv_early", Tx_DV_out, 1'b0);
        @(negedge CLK);
        chk("a5_dv", Tx_DV_out, 1'b1);
        chk("a5_byte", Tx_Byte_out, 8'hA5);
        chk("a5_count0", Count_out, 0);
        chk("a5_empty1", Empty_out, 1'b1);
        @(negedge CLK);
        chk("a5_dv_low", Tx_DV_out, 1'b0);
        push(8'h5A, 1'b1);
        repeat (10) @(negedge CLK);
        chk("hold_no_strobe", strobe_cnt, 1);
        chk("hold_count", Count_out, 1);
        send_done();
        wait_strobe(10);
        @(negedge CLK);
        send_done();
        repeat (5) @(negedge CLK);

        // Burst of five bytes drained through the transmitter model.
        have_done = 1'b0;
        model_en = 1'b1;
        for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
        drain(400);

        // Full FIFO with a push on the pop edge.
        model_en = 1'b0;
        have_done = 1'b0;
        push(8'h99, 1'b1);
        wait_strobe(5);
        for (int i = 0; i < 16; i++) push(8'h60 + 8'(i), 1'b1);
        chk("fill_count", Count_out, 16);
        chk("fill_full", Full_out, 1'b1);
        chk("fill_ovf", Overflow_out, 1'b0);
        model_en = 1'b1;
        send_done();
        @(negedge CLK);
        push(8'hEE, 1'b1);
        chk("pp_dv", Tx_DV_out, 1'b1);
        chk("pp_count", Count_out, 16);
        chk("pp_full", Full_out, 1'b1);
        chk("pp_ovf", Overflow_out, 1'b0);
        drain(1000);

        // Overflow: 17th byte is dropped while the transmitter is stalled.
        model_en = 1'b0;
        have_done = 1'b0;
        push(8'h99, 1'b1);
        wait_strobe(5);
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1'b1);
        chk("ovf_full", Full_out, 1'b1);
        chk("ovf_pre", Overflow_out, 1'b0);
        push(8'h20, 1'b0);
        chk("ovf_set", Overflow_out, 1'b1);
        chk("ovf_count", Count_out, 16);
        model_en = 1'b1;
        send_done();
        drain(1000);
        chk("ovf_sticky", Overflow_out, 1'b1);

        // Reset while BUSY with three bytes queued, then a stray done.
        model_en = 1'b0;
        have_done = 1'b0;
        push(8'h77, 1'b1);
        wait_strobe(5);
        push(8'h31, 1'b0);
        push(8'h32, 1'b0);
        push(8'h33, 1'b0);
        chk("mid_count", Count_out, 3);
        snap = strobe_cnt;
        RST = 1'b0;
        @(negedge CLK);
        check_reset("rst1");
        RST = 1'b1;
        send_done();
        repeat (10) @(negedge CLK);
        chk("stray_strobes", strobe_cnt, snap);
        chk("stray_empty", Empty_out, 1'b1);
        chk("stray_count", Count_out, 0);
        chk("stray_dv", Tx_DV_out, 1'b0);
`else
        // Watchdog: no done ever arrives; flag after 8 BUSY cycles, then normal launch.
        have_done = 1'b0;
        push(8'h3C, 1'b1);
        wait_strobe(5);
        repeat (8) @(negedge CLK);
        chk("wd_pre", Timeout_out, 1'b0);
        @(negedge CLK);
        chk("wd_set", Timeout_out, 1'b1);
        repeat (3) @(negedge CLK);
        push(8'h4D, 1'b1);
        wait_strobe(5);
        chk("wd_byte", Tx_Byte_out, 8'h4D);
        repeat (2) @(negedge CLK);
        chk("wd_sticky", Timeout_out, 1'b1);
        chk("wd_sb", exp_q.size(), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
